// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: sequences the Q/K core through fill, K load, execute and psum drain.
// All inst bits are registered except qmem_wr/kmem_wr, which follow in_valid directly.
module core_seq_ctrl #(
  parameter int total_cycle = 8,
  parameter int col = 8,
  parameter int settle = 10,
  parameter int gap = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] inst,
  output logic        busy,
  output logic        done,
  output logic [2:0]  phase
);
  typedef enum logic [2:0] {IDLE, QWR, KWR, KGAP, KLOAD, SETTLE, EXEC, DRAIN} state_t;
  localparam logic [15:0] TC = 16'(total_cycle);
  localparam logic [15:0] CL = 16'(col);
  localparam logic [15:0] ST = 16'(settle);
  localparam logic [15:0] GP = 16'(gap);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, len;
  logic post, post_n, adv, last, qmem_wr, kmem_wr, kl, kr, ex, dr;
  logic [3:0] addr;
  logic [16:0] inst_q, inst_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      post   <= 1'b0;
      inst_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      post   <= post_n;
      inst_q <= inst_d;
    end
  // SETTLE is shared by both idle stretches; post tells whether execute already ran
  always_comb begin
    len = (state == QWR || state == EXEC || state == DRAIN) ? TC :
          state == KWR ? CL : state == KGAP ? GP : state == KLOAD ? CL + 16'd2 :
          state == SETTLE ? ST : 16'd1;
    adv = (state == QWR || state == KWR) ? in_valid : 1'b1;
    last = adv && cnt == len - 16'd1;
    state_n = state;
    cnt_n = cnt;
    post_n = post;
    if (state == IDLE) begin
      if (start) begin
        state_n = QWR;
        cnt_n = '0;
        post_n = 1'b0;
      end
    end else if (adv) begin
      cnt_n = last ? 16'd0 : cnt + 16'd1;
      if (last) begin
        state_n = state == QWR ? KWR : state == KWR ? KGAP : state == KGAP ? KLOAD :
                  state == KLOAD ? SETTLE : state == SETTLE ? (post ? DRAIN : EXEC) :
                  state == EXEC ? SETTLE : IDLE;
        post_n = state == EXEC;
      end
    end
  end
  always_comb begin
    kl = state_n == KLOAD;
    kr = kl && cnt_n >= 16'd1 && cnt_n <= CL;
    ex = state_n == EXEC;
    dr = state_n == DRAIN;
    addr = (state_n == QWR || state_n == KWR || ex) ? cnt_n[3:0] :
           kr ? cnt_n[3:0] - 4'd1 : 4'd0;
    inst_d = {dr, addr, dr ? cnt_n[3:0] : 4'd0, ex, kl, ex, 1'b0, kr, 1'b0, 1'b0, dr};
    qmem_wr = state == QWR && in_valid;
    kmem_wr = state == KWR && in_valid;
    inst = inst_q | {12'd0, qmem_wr, 1'b0, kmem_wr, 2'd0};
    in_ready = state == QWR || state == KWR;
    busy = state != IDLE;
    done = state == DRAIN && cnt == TC - 16'd1;
    phase = state;
  end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: three differently sized sequencers driven in lockstep against a
// schedule model that derives every cycle's expected instruction from pass arithmetic.
module tb_core_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [16:0] inst_w [3];
  logic [2:0] phase_w [3];
  logic busy_w [3], done_w [3], ready_w [3];
  int tc [3] = '{8, 1, 16};
  int cl [3] = '{8, 16, 1};
  int st [3] = '{10, 3, 1};
  int gp [3] = '{2, 1, 4};
  bit act [3];
  int qb [3], kb [3], t [3], fin [3], dones [3];
  int checks = 0, failures = 0, busy0 = 0;
  bit found;
  always #5 clk = ~clk;
  core_seq_ctrl #(.total_cycle(8), .col(8), .settle(10), .gap(2)) u0 (
    .clk(clk), .reset(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready_w[0]),
    .inst(inst_w[0]), .busy(busy_w[0]), .done(done_w[0]), .phase(phase_w[0]));
  core_seq_ctrl #(.total_cycle(1), .col(16), .settle(3), .gap(1)) u1 (
    .clk(clk), .reset(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready_w[1]),
    .inst(inst_w[1]), .busy(busy_w[1]), .done(done_w[1]), .phase(phase_w[1]));
  core_seq_ctrl #(.total_cycle(16), .col(1), .settle(1), .gap(4)) u2 (
    .clk(clk), .reset(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready_w[2]),
    .inst(inst_w[2]), .busy(busy_w[2]), .done(done_w[2]), .phase(phase_w[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_out(input int d, input logic iv, output logic [16:0] ei,
                           output logic eb, output logic ed, output logic er);
    int u;
    ei = '0; eb = act[d]; ed = 1'b0; er = 1'b0;
    if (act[d]) begin
      if (qb[d] < tc[d]) begin
        er = 1'b1; ei[4] = iv; ei[15:12] = 4'(qb[d]);
      end else if (kb[d] < cl[d]) begin
        er = 1'b1; ei[2] = iv; ei[15:12] = 4'(kb[d]);
      end else begin
        u = t[d] - gp[d];
        if (u >= 0 && u < cl[d] + 2) begin
          ei[6] = 1'b1;
          if (u >= 1 && u <= cl[d]) begin
            ei[3] = 1'b1; ei[15:12] = 4'(u - 1);
          end
        end
        u -= cl[d] + 2 + st[d];
        if (u >= 0 && u < tc[d]) begin
          ei[7] = 1'b1; ei[5] = 1'b1; ei[15:12] = 4'(u);
        end
        u -= tc[d] + st[d];
        if (u >= 0 && u < tc[d]) begin
          ei[16] = 1'b1; ei[0] = 1'b1; ei[11:8] = 4'(u); ed = (u == tc[d] - 1);
        end
      end
    end
  endtask
  task automatic step(input logic s, input logic iv);
    logic [16:0] ei, i;
    logic eb, ed, er;
    @(negedge clk);
    start = s;
    in_valid = iv;
    #1;
    for (int d = 0; d < 3; d++) begin
      model_out(d, iv, ei, eb, ed, er);
      i = inst_w[d];
      check($sformatf("inst%0d", d), 32'(i), 32'(ei));
      check($sformatf("busy%0d", d), 32'(busy_w[d]), 32'(eb));
      check($sformatf("done%0d", d), 32'(done_w[d]), 32'(ed));
      check($sformatf("ready%0d", d), 32'(ready_w[d]), 32'(er));
      check($sformatf("mutex%0d", d), 32'((i[4] & i[2]) | (i[7] & i[6]) | (i[16] & i[7])), 0);
      if (done_w[d]) dones[d]++;
      if (!act[d]) begin
        if (s) begin
          act[d] = 1'b1; qb[d] = 0; kb[d] = 0; t[d] = 0;
        end
      end else if (qb[d] < tc[d]) qb[d] += int'(iv);
      else if (kb[d] < cl[d]) kb[d] += int'(iv);
      else begin
        t[d]++;
        if (t[d] == gp[d] + cl[d] + 2 + 2 * st[d] + 2 * tc[d]) begin
          act[d] = 1'b0; fin[d]++;
        end
      end
    end
    if (busy_w[0]) busy0++;
  endtask
  task automatic check_idle(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_inst%0d", tag, d), 32'(inst_w[d]), 0);
      check($sformatf("%s_busy%0d", tag, d), 32'(busy_w[d]), 0);
      check($sformatf("%s_done%0d", tag, d), 32'(done_w[d]), 0);
      check($sformatf("%s_ready%0d", tag, d), 32'(ready_w[d]), 0);
      check($sformatf("%s_phase%0d", tag, d), 32'(phase_w[d]), 0);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check_idle("por");
    @(negedge clk) rst_n = 1'b1;
    busy0 = 0;
    step(1'b1, 1'b1);
    repeat (110) step(1'b0, 1'b1);
    check("pass_len0", 32'(busy0), 64);
    step(1'b1, 1'b1);
    for (int k = 1; k <= 40; k++) step(1'b0, !(k inside {3, 4, 5, 9, 10, 11}));
    repeat (100) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int k = 1; k <= 80; k++) step(k == 20 || k == 60, 1'b1);
    repeat (80) step(1'b0, 1'b1);
    repeat (600) step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    repeat (100) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(1'b0, 1'b1);
      found = inst_w[0][7] && inst_w[0][15:12] == 4'd3;
    end
    check("exec3_seen", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 check_idle("arst");
    for (int d = 0; d < 3; d++) act[d] = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 1'b1);
    check("restart_addr", 32'(inst_w[0][15:12]), 0);
    repeat (100) step(1'b0, 1'b1);
    for (int d = 0; d < 3; d++) check($sformatf("done_cnt%0d", d), 32'(dones[d]), 32'(fin[d]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
